// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the 5-stage MIPS pipeline: default datapath widths,
// forwarding-select encodings and the ALU control codes used by the decoder,
// the ID/EX stage and the ALU.
package mips_pkg;

    // Default datapath widths
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;
    localparam int DEF_CTRL_WIDTH     = 5;

    // Forwarding select from the hazard unit; 2'b11 also means register read
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // ALU control codes shared with the decoder and the ALU
    localparam logic [DEF_CTRL_WIDTH-1:0] ALU_AND       = 5'd0;
    localparam logic [DEF_CTRL_WIDTH-1:0] ALU_OR        = 5'd1;
    localparam logic [DEF_CTRL_WIDTH-1:0] ALU_ADD       = 5'd2;
    localparam logic [DEF_CTRL_WIDTH-1:0] ALU_SRAV      = 5'd4;
    localparam logic [DEF_CTRL_WIDTH-1:0] ALU_BLTZ_BGEZ = 5'd18;

    // True when a select picks a value from a later pipeline stage, i.e. a
    // value that will leave the pipeline and must be captured on a stall
    function automatic logic isForwarded(input logic [1:0] sel);
        return (sel == FWD_WB) || (sel == FWD_MEM);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux
// 3:1 operand forwarding mux for the execute stage.
// Ports:
//   sel     - forwarding select (00/11 register, 01 MEM/WB, 10 EX/MEM)
//   regVal  - operand read from the register file (ID/EX register)
//   wbVal   - MEM/WB result
//   memVal  - EX/MEM result
//   y       - selected operand
module fwd_mux
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [1:0]            sel,
    input  logic [DATA_WIDTH-1:0] regVal,
    input  logic [DATA_WIDTH-1:0] wbVal,
    input  logic [DATA_WIDTH-1:0] memVal,
    output logic [DATA_WIDTH-1:0] y
);

    // Pick the newest copy of the operand; anything that is not an explicit
    // forward (including the unused 2'b11 code) falls back to the register
    always_comb begin
        y = regVal;
        case (sel)
            FWD_WB:  y = wbVal;
            FWD_MEM: y = memVal;
            default: y = regVal;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register feeding the execute-stage ALU. Latches decoded
// operands and control from ID, applies EX/MEM and MEM/WB forwarding, and
// presents the final ALU operands plus the control that continues to EX/MEM.
// Supports stall (hold), flush (bubble) and capture of a forwarded operand
// during a stall so the value is not lost when it leaves the pipeline.
// Ports:
//   CLK, RST                  - clock, asynchronous active-high reset
//   Stall_E, Flush_E          - hold stage / load bubble (flush wins)
//   Valid_D .. Rd_D           - decoded instruction from ID
//   ForwardA_E, ForwardB_E    - forwarding selects from the hazard unit
//   ALUOut_M, Result_W        - forwarded results from EX/MEM and MEM/WB
//   SrcA_E, SrcB_E, shamt_E,
//   ALU_CTRL_E                - ALU inputs
//   WriteData_E, WriteReg_E,
//   RegWrite_E, MemWrite_E,
//   MemtoReg_E, Valid_E       - control/data travelling on to EX/MEM
//   Rs_E, Rt_E                - source specifiers for the hazard unit
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int CTRL_WIDTH     = DEF_CTRL_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      Stall_E,
    input  logic                      Flush_E,
    input  logic                      Valid_D,
    input  logic [DATA_WIDTH-1:0]     RD1_D,
    input  logic [DATA_WIDTH-1:0]     RD2_D,
    input  logic [DATA_WIDTH-1:0]     SignImm_D,
    input  logic [4:0]                shamt_D,
    input  logic [CTRL_WIDTH-1:0]     ALU_CTRL_D,
    input  logic                      ALUSrc_D,
    input  logic                      RegWrite_D,
    input  logic                      MemWrite_D,
    input  logic                      MemtoReg_D,
    input  logic                      RegDst_D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs_D,
    input  logic [REG_ADDR_WIDTH-1:0] Rt_D,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_D,
    input  logic [1:0]                ForwardA_E,
    input  logic [1:0]                ForwardB_E,
    input  logic [DATA_WIDTH-1:0]     ALUOut_M,
    input  logic [DATA_WIDTH-1:0]     Result_W,
    output logic [DATA_WIDTH-1:0]     SrcA_E,
    output logic [DATA_WIDTH-1:0]     SrcB_E,
    output logic [4:0]                shamt_E,
    output logic [CTRL_WIDTH-1:0]     ALU_CTRL_E,
    output logic [DATA_WIDTH-1:0]     WriteData_E,
    output logic [REG_ADDR_WIDTH-1:0] WriteReg_E,
    output logic                      RegWrite_E,
    output logic                      MemWrite_E,
    output logic                      MemtoReg_E,
    output logic [REG_ADDR_WIDTH-1:0] Rs_E,
    output logic [REG_ADDR_WIDTH-1:0] Rt_E,
    output logic                      Valid_E
);

    logic [DATA_WIDTH-1:0]     rd1E;
    logic [DATA_WIDTH-1:0]     rd2E;
    logic [DATA_WIDTH-1:0]     signImmE;
    logic                      aluSrcE;
    logic                      regDstE;
    logic [REG_ADDR_WIDTH-1:0] rdE;
    logic                      capA;
    logic                      capB;

    logic [DATA_WIDTH-1:0]     fwdRawA;
    logic [DATA_WIDTH-1:0]     fwdRawB;
    logic [DATA_WIDTH-1:0]     fwdA;
    logic [DATA_WIDTH-1:0]     fwdB;
    logic                      captureA;
    logic                      captureB;

    fwd_mux #(.DATA_WIDTH(DATA_WIDTH)) uFwdA (
        .sel    (ForwardA_E),
        .regVal (rd1E),
        .wbVal  (Result_W),
        .memVal (ALUOut_M),
        .y      (fwdRawA)
    );

    fwd_mux #(.DATA_WIDTH(DATA_WIDTH)) uFwdB (
        .sel    (ForwardB_E),
        .regVal (rd2E),
        .wbVal  (Result_W),
        .memVal (ALUOut_M),
        .y      (fwdRawB)
    );

    // Once an operand has been captured during a stall, the captured copy in
    // the register is authoritative and the (now stale) forward select is
    // ignored. A capture happens only on the first stalled edge that sees a
    // real forward, so a longer stall never overwrites the captured value.
    always_comb begin
        fwdA        = capA ? rd1E : fwdRawA;
        fwdB        = capB ? rd2E : fwdRawB;
        captureA    = Stall_E && !capA && isForwarded(ForwardA_E);
        captureB    = Stall_E && !capB && isForwarded(ForwardB_E);
        SrcA_E      = fwdA;
        WriteData_E = fwdB;
        SrcB_E      = aluSrcE ? signImmE : fwdB;
        WriteReg_E  = regDstE ? rdE : Rt_E;
    end

    // Stage register. Priority is reset, flush, stall, then normal load.
    // A flush builds a bubble with every field zeroed so nothing downstream
    // sees stale control; a stall holds everything apart from operand capture.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Valid_E    <= 1'b0;
            RegWrite_E <= 1'b0;
            MemWrite_E <= 1'b0;
            MemtoReg_E <= 1'b0;
            regDstE    <= 1'b0;
            aluSrcE    <= 1'b0;
            ALU_CTRL_E <= '0;
            shamt_E    <= '0;
            rd1E       <= '0;
            rd2E       <= '0;
            signImmE   <= '0;
            Rs_E       <= '0;
            Rt_E       <= '0;
            rdE        <= '0;
            capA       <= 1'b0;
            capB       <= 1'b0;
        end else if (Flush_E) begin
            Valid_E    <= 1'b0;
            RegWrite_E <= 1'b0;
            MemWrite_E <= 1'b0;
            MemtoReg_E <= 1'b0;
            regDstE    <= 1'b0;
            aluSrcE    <= 1'b0;
            ALU_CTRL_E <= '0;
            shamt_E    <= '0;
            rd1E       <= '0;
            rd2E       <= '0;
            signImmE   <= '0;
            Rs_E       <= '0;
            Rt_E       <= '0;
            rdE        <= '0;
            capA       <= 1'b0;
            capB       <= 1'b0;
        end else if (Stall_E) begin
            if (captureA) begin
                rd1E <= fwdRawA;
                capA <= 1'b1;
            end
            if (captureB) begin
                rd2E <= fwdRawB;
                capB <= 1'b1;
            end
        end else begin
            Valid_E    <= Valid_D;
            RegWrite_E <= RegWrite_D;
            MemWrite_E <= MemWrite_D;
            MemtoReg_E <= MemtoReg_D;
            regDstE    <= RegDst_D;
            aluSrcE    <= ALUSrc_D;
            ALU_CTRL_E <= ALU_CTRL_D;
            shamt_E    <= shamt_D;
            rd1E       <= RD1_D;
            rd2E       <= RD2_D;
            signImmE   <= SignImm_D;
            Rs_E       <= Rs_D;
            Rt_E       <= Rt_D;
            rdE        <= Rd_D;
            capA       <= 1'b0;
            capB       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
// Directed testbench for id_ex_stage: reset, load, immediate select,
// forwarding, stall capture and flush-over-stall, with hand-computed
// expected values.
module tb_id_ex_stage;

    logic        CLK;
    logic        RST;
    logic        Stall_E;
    logic        Flush_E;
    logic        Valid_D;
    logic [31:0] RD1_D;
    logic [31:0] RD2_D;
    logic [31:0] SignImm_D;
    logic [4:0]  shamt_D;
    logic [4:0]  ALU_CTRL_D;
    logic        ALUSrc_D;
    logic        RegWrite_D;
    logic        MemWrite_D;
    logic        MemtoReg_D;
    logic        RegDst_D;
    logic [4:0]  Rs_D;
    logic [4:0]  Rt_D;
    logic [4:0]  Rd_D;
    logic [1:0]  ForwardA_E;
    logic [1:0]  ForwardB_E;
    logic [31:0] ALUOut_M;
    logic [31:0] Result_W;
    logic [31:0] SrcA_E;
    logic [31:0] SrcB_E;
    logic [4:0]  shamt_E;
    logic [4:0]  ALU_CTRL_E;
    logic [31:0] WriteData_E;
    logic [4:0]  WriteReg_E;
    logic        RegWrite_E;
    logic        MemWrite_E;
    logic        MemtoReg_E;
    logic [4:0]  Rs_E;
    logic [4:0]  Rt_E;
    logic        Valid_E;

    int total;
    int bad;

    id_ex_stage dut (
        .CLK         (CLK),
        .RST         (RST),
        .Stall_E     (Stall_E),
        .Flush_E     (Flush_E),
        .Valid_D     (Valid_D),
        .RD1_D       (RD1_D),
        .RD2_D       (RD2_D),
        .SignImm_D   (SignImm_D),
        .shamt_D     (shamt_D),
        .ALU_CTRL_D  (ALU_CTRL_D),
        .ALUSrc_D    (ALUSrc_D),
        .RegWrite_D  (RegWrite_D),
        .MemWrite_D  (MemWrite_D),
        .MemtoReg_D  (MemtoReg_D),
        .RegDst_D    (RegDst_D),
        .Rs_D        (Rs_D),
        .Rt_D        (Rt_D),
        .Rd_D        (Rd_D),
        .ForwardA_E  (ForwardA_E),
        .ForwardB_E  (ForwardB_E),
        .ALUOut_M    (ALUOut_M),
        .Result_W    (Result_W),
        .SrcA_E      (SrcA_E),
        .SrcB_E      (SrcB_E),
        .shamt_E     (shamt_E),
        .ALU_CTRL_E  (ALU_CTRL_E),
        .WriteData_E (WriteData_E),
        .WriteReg_E  (WriteReg_E),
        .RegWrite_E  (RegWrite_E),
        .MemWrite_E  (MemWrite_E),
        .MemtoReg_E  (MemtoReg_E),
        .Rs_E        (Rs_E),
        .Rt_E        (Rt_E),
        .Valid_E     (Valid_E)
    );

    // Free-running 10 ns clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single comparison point: counts every check and reports a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one decoded instruction onto the ID-side inputs
    task automatic applyStimulus(input logic valid, input logic [31:0] rd1,
                                 input logic [31:0] rd2, input logic [31:0] imm,
                                 input logic [4:0] shamt, input logic [4:0] ctrl,
                                 input logic aluSrc, input logic regWrite,
                                 input logic memWrite, input logic memtoReg,
                                 input logic regDst, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd);
        Valid_D    = valid;
        RD1_D      = rd1;
        RD2_D      = rd2;
        SignImm_D  = imm;
        shamt_D    = shamt;
        ALU_CTRL_D = ctrl;
        ALUSrc_D   = aluSrc;
        RegWrite_D = regWrite;
        MemWrite_D = memWrite;
        MemtoReg_D = memtoReg;
        RegDst_D   = regDst;
        Rs_D       = rs;
        Rt_D       = rt;
        Rd_D       = rd;
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        RST        = 1'b1;
        Stall_E    = 1'b0;
        Flush_E    = 1'b0;
        ForwardA_E = 2'b00;
        ForwardB_E = 2'b00;
        ALUOut_M   = 32'h0;
        Result_W   = 32'h0;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0,
                      1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

        // Power-on reset state
        #3;
        checkOutput("rst_valid", Valid_E, 1'b0);
        checkOutput("rst_srca", SrcA_E, 32'h0);
        checkOutput("rst_srcb", SrcB_E, 32'h0);
        tick();
        RST = 1'b0;

        // Basic load
        applyStimulus(1'b1, 32'h5, 32'h3, 32'h0, 5'd7, 5'd2, 1'b0, 1'b1,
                      1'b0, 1'b0, 1'b1, 5'd4, 5'd9, 5'd8);
        tick();
        checkOutput("load_srca", SrcA_E, 32'h5);
        checkOutput("load_srcb", SrcB_E, 32'h3);
        checkOutput("load_ctrl", ALU_CTRL_E, 5'd2);
        checkOutput("load_wreg", WriteReg_E, 5'd8);
        checkOutput("load_valid", Valid_E, 1'b1);
        checkOutput("load_regwr", RegWrite_E, 1'b1);
        checkOutput("load_shamt", shamt_E, 5'd7);
        checkOutput("load_rs", Rs_E, 5'd4);
        checkOutput("load_rt", Rt_E, 5'd9);
        checkOutput("load_wdata", WriteData_E, 32'h3);

        // Mid-cycle asynchronous reset with a valid instruction latched
        #2;
        RST = 1'b1;
        #1;
        checkOutput("arst_valid", Valid_E, 1'b0);
        checkOutput("arst_regwr", RegWrite_E, 1'b0);
        checkOutput("arst_srca", SrcA_E, 32'h0);
        checkOutput("arst_srcb", SrcB_E, 32'h0);
        checkOutput("arst_ctrl", ALU_CTRL_E, 5'd0);
        checkOutput("arst_wreg", WriteReg_E, 5'd0);
        #1;
        RST = 1'b0;

        // Immediate select: SrcB takes the immediate, WriteData keeps rt
        applyStimulus(1'b1, 32'h11, 32'h7, 32'hFFFF_FFFC, 5'd0, 5'd2, 1'b1, 1'b0,
                      1'b1, 1'b0, 1'b0, 5'd3, 5'd12, 5'd13);
        tick();
        checkOutput("imm_srcb", SrcB_E, 32'hFFFF_FFFC);
        checkOutput("imm_wdata", WriteData_E, 32'h7);
        checkOutput("imm_wreg", WriteReg_E, 5'd12);
        checkOutput("imm_memwr", MemWrite_E, 1'b1);

        // Forwarding from EX/MEM and MEM/WB
        applyStimulus(1'b1, 32'h100, 32'h200, 32'h0, 5'd0, 5'd2, 1'b0, 1'b1,
                      1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3);
        tick();
        checkOutput("fwd_memtoreg", MemtoReg_E, 1'b1);
        ForwardA_E = 2'b10;
        ALUOut_M   = 32'h1234;
        ForwardB_E = 2'b01;
        Result_W   = 32'hBEEF;
        #1;
        checkOutput("fwd_mem_a", SrcA_E, 32'h1234);
        checkOutput("fwd_wb_b", SrcB_E, 32'hBEEF);
        checkOutput("fwd_wb_wdata", WriteData_E, 32'hBEEF);
        ForwardA_E = 2'b11;
        ForwardB_E = 2'b10;
        #1;
        checkOutput("fwd_11_a", SrcA_E, 32'h100);
        checkOutput("fwd_mem_b", SrcB_E, 32'h1234);

        // Stall capture: A from EX/MEM, B from MEM/WB; ID inputs change but must not load
        applyStimulus(1'b1, 32'h999, 32'h888, 32'h0, 5'd0, 5'd4, 1'b0, 1'b1,
                      1'b0, 1'b0, 1'b1, 5'd5, 5'd6, 5'd7);
        Stall_E    = 1'b1;
        ForwardA_E = 2'b10;
        ALUOut_M   = 32'hAAAA;
        ForwardB_E = 2'b01;
        Result_W   = 32'h7777;
        tick();
        ALUOut_M = 32'h5555;
        Result_W = 32'h8888;
        #1;
        checkOutput("cap_a_edge1", SrcA_E, 32'hAAAA);
        checkOutput("cap_b_edge1", SrcB_E, 32'h7777);
        checkOutput("stall_ctrl_hold", ALU_CTRL_E, 5'd2);
        tick();
        checkOutput("cap_a_norecap", SrcA_E, 32'hAAAA);
        checkOutput("cap_b_norecap", SrcB_E, 32'h7777);
        ForwardA_E = 2'b00;
        ForwardB_E = 2'b00;
        #1;
        checkOutput("cap_a_sel00", SrcA_E, 32'hAAAA);
        checkOutput("stall_rs_hold", Rs_E, 5'd1);
        Stall_E = 1'b0;
        tick();
        checkOutput("cap_release_a", SrcA_E, 32'h999);
        checkOutput("cap_release_ctrl", ALU_CTRL_E, 5'd4);
        ForwardA_E = 2'b10;
        #1;
        checkOutput("cap_cleared_a", SrcA_E, 32'h5555);

        // Flush together with stall, after a capture has been taken
        ForwardA_E = 2'b00;
        applyStimulus(1'b1, 32'h321, 32'h654, 32'h0, 5'd3, 5'd18, 1'b0, 1'b1,
                      1'b1, 1'b1, 1'b1, 5'd10, 5'd11, 5'd12);
        tick();
        checkOutput("pre_flush_ctrl", ALU_CTRL_E, 5'd18);
        Stall_E    = 1'b1;
        ForwardA_E = 2'b10;
        ALUOut_M   = 32'hCCCC;
        tick();
        Flush_E = 1'b1;
        tick();
        Flush_E = 1'b0;
        Stall_E = 1'b0;
        checkOutput("flush_valid", Valid_E, 1'b0);
        checkOutput("flush_regwr", RegWrite_E, 1'b0);
        checkOutput("flush_memwr", MemWrite_E, 1'b0);
        checkOutput("flush_memtoreg", MemtoReg_E, 1'b0);
        checkOutput("flush_ctrl", ALU_CTRL_E, 5'd0);
        ALUOut_M = 32'hDDDD;
        #1;
        checkOutput("flush_cap_cleared", SrcA_E, 32'hDDDD);
        ForwardA_E = 2'b00;
        #1;
        checkOutput("flush_data_zero", SrcA_E, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS pipeline, feeding the execute-stage ALU.
- Latches decoded operands and control from ID, then applies EX/MEM and MEM/WB forwarding.
- Presents the final SrcA, SrcB, shamt and ALU_CTRL to the ALU, plus the control that travels on to EX/MEM.
- Supports stall (hold), flush (bubble insertion) and capture of forwarded operands during a stall, so that a stalled instruction does not lose a value that leaves the pipeline.

Parameters:
- DATA_WIDTH, 32, operand/result width
- REG_ADDR_WIDTH, 5, register-file address width
- CTRL_WIDTH, 5, ALU control code width

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- Stall_E  in  1  hold stage contents
- Flush_E  in  1  load bubble
- Valid_D  in  1  ID holds a real instruction
- RD1_D, RD2_D  in  DATA_WIDTH  register-file read data
- SignImm_D  in  DATA_WIDTH  extended immediate
- shamt_D  in  5  shift amount field
- ALU_CTRL_D  in  CTRL_WIDTH  ALU operation code
- ALUSrc_D, RegWrite_D, MemWrite_D, MemtoReg_D, RegDst_D  in  1 each  decoded control
- Rs_D, Rt_D, Rd_D  in  REG_ADDR_WIDTH  register specifiers
- ForwardA_E, ForwardB_E  in  2  forwarding select: 00 = register, 01 = MEM/WB, 10 = EX/MEM, 11 = register
- ALUOut_M  in  DATA_WIDTH  EX/MEM result
- Result_W  in  DATA_WIDTH  MEM/WB result
- SrcA_E, SrcB_E  out  DATA_WIDTH  ALU operands
- shamt_E  out  5
- ALU_CTRL_E  out  CTRL_WIDTH
- WriteData_E  out  DATA_WIDTH  forwarded rt value, for stores
- WriteReg_E  out  REG_ADDR_WIDTH  destination register: RegDst_E ? Rd_E : Rt_E
- RegWrite_E, MemWrite_E, MemtoReg_E  out  1 each
- Rs_E, Rt_E  out  REG_ADDR_WIDTH  to hazard unit
- Valid_E  out  1

Behaviour:
- Register update priority on the rising edge: RST, then Flush_E, then Stall_E, then normal load.
- Reset (asynchronous, on RST high):
  - all pipeline registers and capture state go to 0;
  - Valid_E = 0, RegWrite_E = 0, MemWrite_E = 0, ALU_CTRL_E = 0, WriteReg_E = 0;
  - SrcA_E = SrcB_E = 0, since the forward selects treat a zero register as a register read.
- Normal load (no flush, no stall): every *_D input moves to its *_E register; capture flags clear.
- Flush_E: the stage is loaded with a bubble.
  - Valid, RegWrite, MemWrite and MemtoReg go to 0, and ALU_CTRL goes to 0.
  - The data registers are don't-care; the implementation zeroes them.
  - Capture flags clear.
  - Flush_E wins over a simultaneous Stall_E.
- Stall_E (no flush): all registers hold, except the operand capture described next.
- Operand capture, per operand, shown for A (B is identical using ForwardB_E, RD2 and capB):
  - At an edge where Stall_E=1 and ForwardA_E is 01 or 10, the current forwarded value is written into RD1_E and capA is set.
  - While capA=1, operand A uses RD1_E and ignores ForwardA_E.
  - capA clears on the next load or flush.
  - A repeated stall with capA already set does not recapture.
- Forwarding (combinational from the E registers):
  - fwdA = ALUOut_M for select 10, Result_W for 01, RD1_E otherwise. fwdB is the same using RD2_E.
  - SrcA_E = fwdA.
  - WriteData_E = fwdB.
  - SrcB_E = ALUSrc_E ? SignImm_E : fwdB.
- Latency: one cycle from ID inputs to E outputs. The forwarding path is zero-latency, combinational.
- Widths: all operand paths are DATA_WIDTH with no extension. shamt passes through unmodified.

Decomposition:
- Shared package mips_pkg holds:
  - forwarding encodings: FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - the ALU_CTRL code constants (AND = 0, OR = 1, ADD = 2, ... SRAV = 4, BLTZ/BGEZ = 18), shared with the ALU and the decoder;
  - DATA_WIDTH and REG_ADDR_WIDTH defaults.
- One natural sub-module, fwd_mux: the 3:1 forwarding mux, instantiated for A and B, with the capture override applied by the parent.

Test Plan:
- Reset: assert RST mid-cycle with a valid instruction latched -> all outputs 0 immediately, before the next edge; Valid_E=0, RegWrite_E=0.
- Basic load: RD1_D=0x00000005, RD2_D=0x00000003, ALU_CTRL_D=2, ALUSrc_D=0, Rd_D=8, RegDst_D=1, one edge -> SrcA_E=5, SrcB_E=3, ALU_CTRL_E=2, WriteReg_E=8.
- Immediate select: ALUSrc_D=1, SignImm_D=0xFFFFFFFC, RD2_D=7 -> SrcB_E=0xFFFFFFFC, WriteData_E=7.
- Forward priority: ForwardA_E=10 with ALUOut_M=0x1234 -> SrcA_E=0x1234; ForwardB_E=01 with Result_W=0xBEEF -> SrcB_E=0xBEEF, given ALUSrc_E=0.
- Stall capture: ForwardA_E=10, ALUOut_M=0xAAAA, Stall_E=1 for 2 edges, then ALUOut_M=0x5555 and ForwardA_E=00 -> SrcA_E stays 0xAAAA until the next load.
- Flush + stall together: Flush_E=1, Stall_E=1 -> Valid_E=0, RegWrite_E=0, MemWrite_E=0, ALU_CTRL_E=0, capture flags cleared.
